// File: rtl/irq_ctrl_vec.sv
// Vectored interrupt controller: per-line synchroniser, level/edge pending logic,
// lowest-index-wins selection and single in-service tracking until mret.
module irq_ctrl_vec #(
  parameter int unsigned      N_IRQ       = 16,
  parameter logic [N_IRQ-1:0] EDGE_MASK   = '0,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      CAUSE_BASE  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [N_IRQ-1:0] irq_mask_i,
  input  logic             mie_i,
  input  logic             exception_i,
  input  logic             mret_i,
  output logic             irq_o,
  output logic [31:0]      irq_cause_o,
  output logic [N_IRQ-1:0] irq_ret_o,
  output logic             busy_o
);

  localparam int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic {IDLE = 1'b0, SERVICE = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_IRQ-1:0]   pend_q, pend_d;
  logic [N_IRQ-1:0]   prev_q, prev_d;
  logic [N_IRQ-1:0]   s;
  logic [N_IRQ-1:0]   rise;
  logic [N_IRQ-1:0]   pend;
  logic [N_IRQ-1:0]   elig;
  logic [N_IRQ-1:0]   claim;
  logic [IDX_W-1:0]   sel;
  logic               any_elig;
  logic               take;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = irq_req_i;
    end else begin : g_sync
      logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
      logic [N_IRQ-1:0] sync_d [SYNC_STAGES];

      always_comb begin
        sync_d[0] = irq_req_i;
        for (int k = 1; k < int'(SYNC_STAGES); k++) begin
          sync_d[k] = sync_q[k-1];
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int k = 0; k < int'(SYNC_STAGES); k++) begin
            sync_q[k] <= '0;
          end
        end else begin
          for (int k = 0; k < int'(SYNC_STAGES); k++) begin
            sync_q[k] <= sync_d[k];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Level lines bypass the pending register; only edge lines latch.
  assign rise     = s & ~prev_q & EDGE_MASK;
  assign pend     = (pend_q & EDGE_MASK) | (s & ~EDGE_MASK);
  assign elig     = pend & irq_mask_i;
  assign any_elig = |elig;
  assign take     = (state_q == IDLE) & mie_i & any_elig & ~exception_i;

  always_comb begin
    sel = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (elig[i]) sel = IDX_W'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      prev_q  <= prev_d;
    end
  end

  // An exception freezes the FSM, but edges arriving meanwhile are still latched.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    claim   = '0;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d    = SERVICE;
          idx_d      = sel;
          claim[sel] = 1'b1;
        end
      end
      SERVICE: begin
        if (mret_i && !exception_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pend_d = ((pend_q & ~claim) | rise) & EDGE_MASK;
    prev_d = s;
  end

  always_comb begin
    irq_o       = 1'b0;
    irq_cause_o = '0;
    irq_ret_o   = '0;
    busy_o      = (state_q == SERVICE);
    case (state_q)
      IDLE: begin
        irq_o = take;
        if (any_elig) irq_cause_o = {1'b1, 31'(CAUSE_BASE + 32'(sel))};
      end
      SERVICE: begin
        irq_cause_o = {1'b1, 31'(CAUSE_BASE + 32'(idx_q))};
        if (mret_i && !exception_i) irq_ret_o[idx_q] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl_vec.sv
// Bench for irq_ctrl_vec: directed scenarios plus random traffic, checked per cycle
// against a queue-based reference model through a scoreboard.
module tb_irq_ctrl_vec;

  localparam int          N     = 16;
  localparam logic [15:0] EDGE  = 16'h8181;
  localparam int          SYNC  = 2;
  localparam int          BASE  = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] irq_req_i = '0;
  logic [15:0] irq_mask_i = '0;
  logic        mie_i = 1'b0;
  logic        exception_i = 1'b0;
  logic        mret_i = 1'b0;
  logic        irq_o;
  logic [31:0] irq_cause_o;
  logic [15:0] irq_ret_o;
  logic        busy_o;

  irq_ctrl_vec #(
    .N_IRQ(N), .EDGE_MASK(EDGE), .SYNC_STAGES(SYNC), .CAUSE_BASE(BASE)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .irq_req_i(irq_req_i), .irq_mask_i(irq_mask_i),
    .mie_i(mie_i), .exception_i(exception_i), .mret_i(mret_i), .irq_o(irq_o),
    .irq_cause_o(irq_cause_o), .irq_ret_o(irq_ret_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit        irq;
    bit [31:0] cause;
    bit [15:0] ret;
    bit        busy;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: requests seen by the controller are the inputs from SYNC cycles ago.
  bit [15:0] hist[$];
  bit [15:0] m_prev, m_pend;
  bit        m_busy;
  int        m_idx;

  function automatic bit [31:0] cause_of(int line);
    return 32'h8000_0000 | 32'(BASE + line);
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < SYNC; k++) hist.push_back(16'h0);
    m_prev = '0;
    m_pend = '0;
    m_busy = 1'b0;
    m_idx  = 0;
  endtask

  task automatic model_step(input bit rst, input bit [15:0] req, input bit [15:0] mask,
                            input bit mie, input bit exc, input bit mret, output exp_t e);
    bit [15:0] s, pendv, elig, rise;
    int sel;
    e = '{irq: 1'b0, cause: 32'h0, ret: 16'h0, busy: 1'b0};
    if (!rst) begin
      model_reset();
      return;
    end
    s     = (SYNC == 0) ? req : hist[0];
    pendv = (m_pend & EDGE) | (s & ~EDGE);
    elig  = pendv & mask;
    sel   = 0;
    for (int i = N - 1; i >= 0; i--) if (elig[i]) sel = i;
    if (!m_busy) begin
      e.irq   = mie && (elig != 0) && !exc;
      e.cause = (elig != 0) ? cause_of(sel) : 32'h0;
    end else begin
      e.busy  = 1'b1;
      e.cause = cause_of(m_idx);
      e.ret   = (mret && !exc) ? (16'h1 << m_idx) : 16'h0;
    end
    rise = s & ~m_prev & EDGE;
    if (!m_busy && e.irq) begin
      m_busy      = 1'b1;
      m_idx       = sel;
      m_pend[sel] = 1'b0;
    end else if (m_busy && mret && !exc) begin
      m_busy = 1'b0;
    end
    m_pend = (m_pend | rise) & EDGE;
    m_prev = s;
    if (SYNC > 0) begin
      void'(hist.pop_front());
      hist.push_back(req);
    end
  endtask

  // One cycle: drive just after the rising edge, return just after the falling edge.
  task automatic drive(input bit rst, input bit [15:0] req, input bit [15:0] mask,
                       input bit mie, input bit exc, input bit mret);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_ni      = rst;
    irq_req_i   = req;
    irq_mask_i  = mask;
    mie_i       = mie;
    exception_i = exc;
    mret_i      = mret;
    model_step(rst, req, mask, mie, exc, mret, e);
    sbq.push_back(e);
    @(negedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input bit [31:0] act, input bit [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (irq_o !== e.irq || irq_cause_o !== e.cause || irq_ret_o !== e.ret || busy_o !== e.busy) begin
        errors++;
        $display("FAIL cycle t=%0t: got irq=%b cause=%h ret=%h busy=%b expected irq=%b cause=%h ret=%h busy=%b",
                 $time, irq_o, irq_cause_o, irq_ret_o, busy_o, e.irq, e.cause, e.ret, e.busy);
      end else if (e.irq) begin
        $display("trap   t=%0t cause=%h", $time, e.cause);
      end else if (e.ret != 0) begin
        $display("return t=%0t ack=%h", $time, e.ret);
      end
    end
  end

  initial begin
    bit [15:0] lvl;
    bit        rst;
    model_reset();

    drive(0, 16'h0, 16'h0, 0, 0, 0);
    chk("reset_irq", 32'(irq_o), 32'h0);
    chk("reset_busy", 32'(busy_o), 32'h0);
    drive(0, 16'h0, 16'h0, 0, 0, 0);

    // Level line 3 through two synchroniser stages
    drive(1, 16'h0008, 16'h0008, 1, 0, 0);
    drive(1, 16'h0008, 16'h0008, 1, 0, 0);
    chk("lvl3_early", 32'(irq_o), 32'h0);
    drive(1, 16'h0008, 16'h0008, 1, 0, 0);
    chk("lvl3_irq", 32'(irq_o), 32'h1);
    chk("lvl3_cause", irq_cause_o, 32'h8000_0013);
    drive(1, 16'h0000, 16'h0008, 1, 0, 0);
    drive(1, 16'h0000, 16'h0008, 1, 0, 0);
    chk("lvl3_busy", 32'(busy_o), 32'h1);
    drive(1, 16'h0000, 16'h0008, 1, 0, 1);
    chk("lvl3_ret", 32'(irq_ret_o), 32'h0008);
    drive(1, 16'h0000, 16'h0008, 1, 0, 0);
    chk("lvl3_busy_fall", 32'(busy_o), 32'h0);

    // Lines 5 and 2 together: lowest index first
    drive(1, 16'h0024, 16'h0024, 1, 0, 0);
    drive(1, 16'h0024, 16'h0024, 1, 0, 0);
    drive(1, 16'h0024, 16'h0024, 1, 0, 0);
    chk("prio_cause2", irq_cause_o, 32'h8000_0012);
    drive(1, 16'h0020, 16'h0024, 1, 0, 0);
    drive(1, 16'h0020, 16'h0024, 1, 0, 0);
    drive(1, 16'h0020, 16'h0024, 1, 0, 1);
    drive(1, 16'h0000, 16'h0024, 1, 0, 0);
    chk("prio_irq5", 32'(irq_o), 32'h1);
    chk("prio_cause5", irq_cause_o, 32'h8000_0015);
    drive(1, 16'h0000, 16'h0024, 1, 0, 0);
    drive(1, 16'h0000, 16'h0024, 1, 0, 1);
    for (int k = 0; k < 3; k++) drive(1, 16'h0000, 16'h0024, 1, 0, 0);

    // Edge line 0: single pulse, then two pulses merged during service
    drive(1, 16'h0001, 16'h0001, 1, 0, 0);
    drive(1, 16'h0000, 16'h0001, 1, 0, 0);
    drive(1, 16'h0000, 16'h0001, 1, 0, 0);
    chk("edge_early", 32'(irq_o), 32'h0);
    drive(1, 16'h0000, 16'h0001, 1, 0, 0);
    chk("edge_irq", 32'(irq_o), 32'h1);
    chk("edge_cause", irq_cause_o, 32'h8000_0010);
    drive(1, 16'h0001, 16'h0001, 1, 0, 0);
    drive(1, 16'h0000, 16'h0001, 1, 0, 0);
    drive(1, 16'h0001, 16'h0001, 1, 0, 0);
    for (int k = 0; k < 3; k++) drive(1, 16'h0000, 16'h0001, 1, 0, 0);
    drive(1, 16'h0000, 16'h0001, 1, 0, 1);
    drive(1, 16'h0000, 16'h0001, 1, 0, 0);
    chk("edge_retrap", 32'(irq_o), 32'h1);
    drive(1, 16'h0000, 16'h0001, 1, 0, 1);
    drive(1, 16'h0000, 16'h0001, 1, 0, 0);
    chk("edge_merged", 32'(irq_o), 32'h0);

    // Exception blocks the trap for one cycle
    drive(1, 16'h0010, 16'h0010, 1, 0, 0);
    drive(1, 16'h0010, 16'h0010, 1, 0, 0);
    drive(1, 16'h0010, 16'h0010, 1, 1, 0);
    chk("exc_block", 32'(irq_o), 32'h0);
    chk("exc_idle", 32'(busy_o), 32'h0);
    drive(1, 16'h0000, 16'h0010, 1, 0, 0);
    chk("exc_after", 32'(irq_o), 32'h1);
    chk("exc_cause", irq_cause_o, 32'h8000_0014);
    for (int k = 0; k < 3; k++) drive(1, 16'h0000, 16'h0010, 1, 0, 0);
    drive(1, 16'h0000, 16'h0010, 1, 0, 1);

    // Masking and global enable
    drive(1, 16'h0010, 16'h0000, 1, 0, 0);
    drive(1, 16'h0010, 16'h0000, 1, 0, 0);
    drive(1, 16'h0010, 16'h0000, 1, 0, 0);
    chk("masked", 32'(irq_o), 32'h0);
    drive(1, 16'h0010, 16'h0010, 0, 0, 0);
    chk("mie_off", 32'(irq_o), 32'h0);
    drive(1, 16'h0000, 16'h0010, 1, 0, 0);
    chk("unmask", 32'(irq_o), 32'h1);
    for (int k = 0; k < 3; k++) drive(1, 16'h0000, 16'h0010, 1, 0, 0);
    drive(1, 16'h0000, 16'h0010, 1, 0, 1);
    drive(1, 16'h0000, 16'h0010, 1, 0, 1);
    chk("mret_idle", 32'(irq_ret_o), 32'h0);

    // Reset in the middle of service
    for (int k = 0; k < 3; k++) drive(1, 16'h0008, 16'h0008, 1, 0, 0);
    drive(1, 16'h0000, 16'h0008, 1, 0, 0);
    chk("pre_rst_busy", 32'(busy_o), 32'h1);
    drive(0, 16'h0000, 16'h0008, 1, 0, 1);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_ret", 32'(irq_ret_o), 32'h0);
    chk("rst_cause", irq_cause_o, 32'h0);
    for (int k = 0; k < 4; k++) drive(1, 16'h0000, 16'h0008, 1, 0, 0);
    chk("rst_no_trap", 32'(irq_o), 32'h0);

    // Random traffic
    lvl = '0;
    for (int c = 0; c < 2000; c++) begin
      bit [15:0] flips, req, mask;
      flips = 16'($urandom) & 16'($urandom) & 16'($urandom);
      lvl   = (lvl ^ flips) & ~EDGE;
      req   = lvl | (16'($urandom) & 16'($urandom) & 16'($urandom) & EDGE);
      mask  = 16'($urandom) | 16'($urandom);
      rst   = ($urandom_range(0, 299) != 0);
      drive(rst, req, mask, ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
    end

    @(negedge clk_i);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
